// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Brief    : Registered ALU with valid/ready handshakes, ADC and shift-add MUL.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       S,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam int              c_cnt_w    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

    localparam logic [3:0] c_op_add = 4'b0000;
    localparam logic [3:0] c_op_sub = 4'b0001;
    localparam logic [3:0] c_op_neg = 4'b0010;
    localparam logic [3:0] c_op_inc = 4'b0011;
    localparam logic [3:0] c_op_dec = 4'b0100;
    localparam logic [3:0] c_op_and = 4'b0101;
    localparam logic [3:0] c_op_or  = 4'b0110;
    localparam logic [3:0] c_op_xor = 4'b0111;
    localparam logic [3:0] c_op_not = 4'b1000;
    localparam logic [3:0] c_op_shl = 4'b1001;
    localparam logic [3:0] c_op_shr = 4'b1010;
    localparam logic [3:0] c_op_sar = 4'b1011;
    localparam logic [3:0] c_op_rol = 4'b1100;
    localparam logic [3:0] c_op_ror = 4'b1101;
    localparam logic [3:0] c_op_adc = 4'b1110;
    localparam logic [3:0] c_op_mul = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_y;
    logic                 r_cout;
    logic                 r_zero;
    logic                 r_neg;
    logic                 r_ovf;
    logic                 r_carry_flag;

    logic [2*WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_mplier;
    logic [c_cnt_w-1:0]   r_cnt;

    logic                 w_free;
    logic                 w_accept;
    logic                 w_mul_start;
    logic                 w_mul_last;
    logic                 w_load_alu;
    logic                 w_load_mul;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [2*WIDTH-1:0]   w_mul_prod;

    logic [WIDTH-1:0]     w_add_a;
    logic [WIDTH-1:0]     w_add_b;
    logic                 w_add_cin;
    logic [WIDTH:0]       w_sum;
    logic                 w_add_ovf;

    logic [WIDTH-1:0]     w_res;
    logic                 w_res_cout;
    logic                 w_res_ovf;

    logic [WIDTH-1:0]     w_ld_y;
    logic                 w_ld_cout;
    logic                 w_ld_ovf;

    assign w_free      = !r_out_valid || out_ready;
    assign in_ready    = (r_state == ST_IDLE) && w_free;
    assign w_accept    = in_valid && in_ready;
    assign w_mul_start = w_accept && (S == c_op_mul);
    assign w_load_alu  = w_accept && (S != c_op_mul);
    assign w_mul_last  = (r_state == ST_MUL) && (r_cnt == c_cnt_last);
    assign w_load_mul  = (w_mul_last || (r_state == ST_WAIT)) && w_free;

    assign w_acc_next  = r_acc + (r_mplier[0] ? r_mcand : '0);
    // In WAIT the finished product already sits in the accumulator.
    assign w_mul_prod  = (r_state == ST_WAIT) ? r_acc : w_acc_next;

    // One shared adder serves every arithmetic opcode by steering its operands.
    always_comb begin
        w_add_a   = A;
        w_add_b   = B;
        w_add_cin = 1'b0;
        case (S)
            c_op_sub: begin
                w_add_b   = ~B;
                w_add_cin = 1'b1;
            end
            c_op_neg: begin
                w_add_a   = '0;
                w_add_b   = ~B;
                w_add_cin = 1'b1;
            end
            c_op_inc: begin
                w_add_b   = '0;
                w_add_cin = 1'b1;
            end
            c_op_dec: w_add_b   = '1;
            c_op_adc: w_add_cin = r_carry_flag;
            default:  ;
        endcase
    end

    assign w_sum     = {1'b0, w_add_a} + {1'b0, w_add_b} + {{WIDTH{1'b0}}, w_add_cin};
    assign w_add_ovf = (w_add_a[WIDTH-1] == w_add_b[WIDTH-1]) &&
                       (w_sum[WIDTH-1] != w_add_a[WIDTH-1]);

    always_comb begin
        w_res      = '0;
        w_res_cout = 1'b0;
        w_res_ovf  = 1'b0;
        case (S)
            c_op_add, c_op_sub, c_op_neg, c_op_inc, c_op_dec, c_op_adc: begin
                w_res      = w_sum[WIDTH-1:0];
                w_res_cout = w_sum[WIDTH];
                w_res_ovf  = w_add_ovf;
            end
            c_op_and: w_res = A & B;
            c_op_or:  w_res = A | B;
            c_op_xor: w_res = A ^ B;
            c_op_not: w_res = ~A;
            c_op_shl: begin
                w_res      = {A[WIDTH-2:0], 1'b0};
                w_res_cout = A[WIDTH-1];
            end
            c_op_shr: begin
                w_res      = {1'b0, A[WIDTH-1:1]};
                w_res_cout = A[0];
            end
            c_op_sar: begin
                w_res      = {A[WIDTH-1], A[WIDTH-1:1]};
                w_res_cout = A[0];
            end
            c_op_rol: begin
                w_res      = {A[WIDTH-2:0], A[WIDTH-1]};
                w_res_cout = A[WIDTH-1];
            end
            c_op_ror: begin
                w_res      = {A[0], A[WIDTH-1:1]};
                w_res_cout = A[0];
            end
            default:  ;
        endcase
    end

    always_comb begin
        w_ld_y    = w_res;
        w_ld_cout = w_res_cout;
        w_ld_ovf  = w_res_ovf;
        if (w_load_mul) begin
            w_ld_y    = w_mul_prod[WIDTH-1:0];
            w_ld_cout = |w_mul_prod[2*WIDTH-1:WIDTH];
            w_ld_ovf  = 1'b0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_mul_start) w_state_next = ST_MUL;
            ST_MUL:  if (w_mul_last)  w_state_next = w_free ? ST_IDLE : ST_WAIT;
            ST_WAIT: if (w_free)      w_state_next = ST_IDLE;
            default:                  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (w_mul_start) begin
            r_mcand  <= {{WIDTH{1'b0}}, A};
            r_acc    <= '0;
            r_mplier <= B;
            r_cnt    <= '0;
        end else if (r_state == ST_MUL) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + c_cnt_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_y          <= '0;
            r_cout       <= 1'b0;
            r_zero       <= 1'b0;
            r_neg        <= 1'b0;
            r_ovf        <= 1'b0;
            r_carry_flag <= 1'b0;
        end else if (w_load_alu || w_load_mul) begin
            r_out_valid  <= 1'b1;
            r_y          <= w_ld_y;
            r_cout       <= w_ld_cout;
            r_zero       <= (w_ld_y == '0);
            r_neg        <= w_ld_y[WIDTH-1];
            r_ovf        <= w_ld_ovf;
            r_carry_flag <= w_ld_cout;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign cout      = r_cout;
    assign zero      = r_zero;
    assign neg       = r_neg;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire
